// File: rtl/bus_cycle_scheduler.sv
// Two-requester 68k bus-transfer scheduler: arbitrates HOST/AUX, sequences the bus FSM, splits longs, returns one response per request.
// Optional build macro SCHED_AUX_PRIORITY_EN: AUX always wins over HOST (quota counter removed).
module bus_cycle_scheduler #(
    parameter int ADDR_W     = 24,
    parameter int HOST_QUOTA = 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              H_VALID,
    output logic              H_READY,
    input  logic [ADDR_W-1:0] H_ADDR,
    input  logic [31:0]       H_WDATA,
    input  logic [1:0]        H_SIZE,
    input  logic              H_RW,
    input  logic [2:0]        H_FC,
    input  logic              A_VALID,
    output logic              A_READY,
    input  logic [ADDR_W-1:0] A_ADDR,
    input  logic [31:0]       A_WDATA,
    input  logic [1:0]        A_SIZE,
    input  logic              A_RW,
    input  logic [2:0]        A_FC,
    output logic              FSM_ACTIVATE,
    output logic              MUST_CONTINUE,
    input  logic              FSM_FINALIZE,
    input  logic              FSM_LATCH,
    input  logic [15:0]       RD_WORD,
    output logic [ADDR_W-1:0] CYC_ADDR,
    output logic [15:0]       CYC_WDATA,
    output logic              CYC_BYTE,
    output logic              CYC_RW,
    output logic [2:0]        CYC_FC,
    output logic              RESP_VALID,
    input  logic              RESP_READY,
    output logic              RESP_ID,
    output logic [31:0]       RESP_DATA,
    output logic              RESP_ERR
);

    typedef enum logic [1:0] {IDLE, ISSUE, RUN, RESP} state_t;

    state_t            state_q, state_d;
    logic              phase_q, phase_d;
    logic              long_q, long_d;
    logic              a0_q, a0_d;
    logic [15:0]       wlo_q, wlo_d;
    logic [ADDR_W-1:0] cyc_addr_q, cyc_addr_d;
    logic [15:0]       cyc_wdata_q, cyc_wdata_d;
    logic              cyc_byte_q, cyc_byte_d;
    logic              cyc_rw_q, cyc_rw_d;
    logic [2:0]        cyc_fc_q, cyc_fc_d;
    logic              must_cont_q, must_cont_d;
    logic              resp_id_q, resp_id_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              grant_h, grant_a;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [1:0]        req_size;
    logic              req_rw;
    logic [2:0]        req_fc;
    logic              req_rej;

    // Grants are suppressed while RESET is high so nothing is accepted into a state being cleared.
`ifdef SCHED_AUX_PRIORITY_EN
    always_comb begin
        grant_a = (state_q == IDLE) && !RESET && A_VALID;
        grant_h = (state_q == IDLE) && !RESET && H_VALID && !A_VALID;
    end
`else
    logic [31:0] quota_q, quota_d;

    always_comb begin
        grant_h = 1'b0;
        grant_a = 1'b0;
        quota_d = quota_q;
        if (state_q == IDLE && !RESET) begin
            if (H_VALID && A_VALID) begin
                if (quota_q < 32'(HOST_QUOTA)) begin
                    grant_h = 1'b1;
                    quota_d = quota_q + 32'd1;
                end else begin
                    grant_a = 1'b1;
                    quota_d = '0;
                end
            end else if (H_VALID) begin
                grant_h = 1'b1;
                quota_d = '0;
            end else if (A_VALID) begin
                grant_a = 1'b1;
                quota_d = '0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) quota_q <= '0;
        else       quota_q <= quota_d;
    end
`endif

    always_comb begin
        req_addr  = grant_a ? A_ADDR  : H_ADDR;
        req_wdata = grant_a ? A_WDATA : H_WDATA;
        req_size  = grant_a ? A_SIZE  : H_SIZE;
        req_rw    = grant_a ? A_RW    : H_RW;
        req_fc    = grant_a ? A_FC    : H_FC;
        req_rej   = (req_size == 2'd3) || ((req_size != 2'd0) && req_addr[0]);
    end

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        long_d      = long_q;
        a0_d        = a0_q;
        wlo_d       = wlo_q;
        cyc_addr_d  = cyc_addr_q;
        cyc_wdata_d = cyc_wdata_q;
        cyc_byte_d  = cyc_byte_q;
        cyc_rw_d    = cyc_rw_q;
        cyc_fc_d    = cyc_fc_q;
        must_cont_d = must_cont_q;
        resp_id_d   = resp_id_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        case (state_q)
            IDLE: begin
                if (grant_h || grant_a) begin
                    resp_id_d   = grant_a;
                    rdata_d     = '0;
                    err_d       = req_rej;
                    cyc_addr_d  = req_addr;
                    cyc_rw_d    = req_rw;
                    cyc_fc_d    = req_fc;
                    cyc_byte_d  = (req_size == 2'd0);
                    long_d      = (req_size == 2'd2);
                    a0_d        = req_addr[0];
                    wlo_d       = req_wdata[15:0];
                    phase_d     = 1'b0;
                    must_cont_d = !req_rej && (req_size == 2'd2);
                    case (req_size)
                        2'd0:    cyc_wdata_d = {req_wdata[7:0], req_wdata[7:0]};
                        2'd2:    cyc_wdata_d = req_wdata[31:16];
                        default: cyc_wdata_d = req_wdata[15:0];
                    endcase
                    state_d = req_rej ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                phase_d = 1'b0;
                state_d = RUN;
            end
            RUN: begin
                if (FSM_LATCH && cyc_rw_q) begin
                    if (long_q && !phase_q)
                        rdata_d[31:16] = RD_WORD;
                    else if (cyc_byte_q)
                        rdata_d = {24'd0, a0_q ? RD_WORD[7:0] : RD_WORD[15:8]};
                    else
                        rdata_d[15:0] = RD_WORD;
                end
                // Second word of a long: the bus FSM re-enters SETUP on its own, no new ACTIVATE.
                if (FSM_FINALIZE) begin
                    if (must_cont_q) begin
                        phase_d     = 1'b1;
                        must_cont_d = 1'b0;
                        cyc_addr_d  = cyc_addr_q + ADDR_W'(2);
                        cyc_wdata_d = wlo_q;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                if (RESP_READY) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= IDLE;
            phase_q     <= 1'b0;
            long_q      <= 1'b0;
            a0_q        <= 1'b0;
            wlo_q       <= '0;
            cyc_addr_q  <= '0;
            cyc_wdata_q <= '0;
            cyc_byte_q  <= 1'b0;
            cyc_rw_q    <= 1'b0;
            cyc_fc_q    <= '0;
            must_cont_q <= 1'b0;
            resp_id_q   <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            long_q      <= long_d;
            a0_q        <= a0_d;
            wlo_q       <= wlo_d;
            cyc_addr_q  <= cyc_addr_d;
            cyc_wdata_q <= cyc_wdata_d;
            cyc_byte_q  <= cyc_byte_d;
            cyc_rw_q    <= cyc_rw_d;
            cyc_fc_q    <= cyc_fc_d;
            must_cont_q <= must_cont_d;
            resp_id_q   <= resp_id_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    assign H_READY       = grant_h;
    assign A_READY       = grant_a;
    assign FSM_ACTIVATE  = (state_q == ISSUE);
    assign MUST_CONTINUE = must_cont_q;
    assign CYC_ADDR      = cyc_addr_q;
    assign CYC_WDATA     = cyc_wdata_q;
    assign CYC_BYTE      = cyc_byte_q;
    assign CYC_RW        = cyc_rw_q;
    assign CYC_FC        = cyc_fc_q;
    assign RESP_VALID    = (state_q == RESP);
    assign RESP_ID       = resp_id_q;
    assign RESP_DATA     = rdata_q;
    assign RESP_ERR      = err_q;

endmodule

// File: tb/tb_bus_cycle_scheduler.sv
// Scoreboard bench for bus_cycle_scheduler: directed requests, a small bus-FSM model, and monitors for grants, ACTIVATE and responses.
module tb_bus_cycle_scheduler;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        H_VALID, H_READY, A_VALID, A_READY;
    logic [23:0] H_ADDR, A_ADDR;
    logic [31:0] H_WDATA, A_WDATA;
    logic [1:0]  H_SIZE, A_SIZE;
    logic        H_RW, A_RW;
    logic [2:0]  H_FC, A_FC;
    logic        FSM_ACTIVATE, MUST_CONTINUE, FSM_FINALIZE, FSM_LATCH;
    logic [15:0] RD_WORD;
    logic [23:0] CYC_ADDR;
    logic [15:0] CYC_WDATA;
    logic        CYC_BYTE, CYC_RW;
    logic [2:0]  CYC_FC;
    logic        RESP_VALID, RESP_READY, RESP_ID, RESP_ERR;
    logic [31:0] RESP_DATA;

    always #5 CLK = ~CLK;

    bus_cycle_scheduler #(.ADDR_W(24), .HOST_QUOTA(2)) dut (
        .CLK(CLK), .RESET(RESET),
        .H_VALID(H_VALID), .H_READY(H_READY), .H_ADDR(H_ADDR), .H_WDATA(H_WDATA),
        .H_SIZE(H_SIZE), .H_RW(H_RW), .H_FC(H_FC),
        .A_VALID(A_VALID), .A_READY(A_READY), .A_ADDR(A_ADDR), .A_WDATA(A_WDATA),
        .A_SIZE(A_SIZE), .A_RW(A_RW), .A_FC(A_FC),
        .FSM_ACTIVATE(FSM_ACTIVATE), .MUST_CONTINUE(MUST_CONTINUE),
        .FSM_FINALIZE(FSM_FINALIZE), .FSM_LATCH(FSM_LATCH), .RD_WORD(RD_WORD),
        .CYC_ADDR(CYC_ADDR), .CYC_WDATA(CYC_WDATA), .CYC_BYTE(CYC_BYTE),
        .CYC_RW(CYC_RW), .CYC_FC(CYC_FC),
        .RESP_VALID(RESP_VALID), .RESP_READY(RESP_READY), .RESP_ID(RESP_ID),
        .RESP_DATA(RESP_DATA), .RESP_ERR(RESP_ERR)
    );

    typedef struct packed {
        logic [23:0] addr; logic [31:0] wdata; logic [1:0] size; logic rw; logic [2:0] fc;
    } req_t;
    typedef struct packed {
        logic id; logic [31:0] data; logic err;
    } resp_t;
    typedef struct packed {
        logic [23:0] addr; logic [15:0] wdata; logic byt; logic rw; logic mc; logic [2:0] fc; logic [15:0] rd;
    } cyc_t;

    resp_t exp_resp[$];
    cyc_t  exp_cyc[$];
    logic  exp_grant[$];

    int   n_vec = 0;
    int   n_err = 0;
    logic mon_en = 1'b0;
    logic model_en = 1'b1;
    logic exp_act = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    function automatic req_t mk_req(input logic [23:0] a, input logic [31:0] d,
                                    input logic [1:0] s, input logic rw, input logic [2:0] fc);
        req_t r;
        r.addr = a; r.wdata = d; r.size = s; r.rw = rw; r.fc = fc;
        return r;
    endfunction

    function automatic resp_t mk_resp(input logic id, input logic [31:0] d, input logic e);
        resp_t r;
        r.id = id; r.data = d; r.err = e;
        return r;
    endfunction

    function automatic cyc_t mk_cyc(input logic [23:0] a, input logic [15:0] w, input logic b,
                                    input logic rw, input logic mc, input logic [2:0] fc,
                                    input logic [15:0] rd);
        cyc_t c;
        c.addr = a; c.wdata = w; c.byt = b; c.rw = rw; c.mc = mc; c.fc = fc; c.rd = rd;
        return c;
    endfunction

    // Present a request on one port and hold it until READY is seen.
    task automatic issue(input logic who, input req_t r);
        logic got;
        got = 1'b0;
        if (who) begin
            A_VALID = 1'b1; A_ADDR = r.addr; A_WDATA = r.wdata; A_SIZE = r.size; A_RW = r.rw; A_FC = r.fc;
        end else begin
            H_VALID = 1'b1; H_ADDR = r.addr; H_WDATA = r.wdata; H_SIZE = r.size; H_RW = r.rw; H_FC = r.fc;
        end
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge CLK);
            got = who ? A_READY : H_READY;
            tick();
        end
        if (!got) fail_now(who ? "aux_ready_timeout" : "host_ready_timeout");
        if (who) A_VALID = 1'b0;
        else     H_VALID = 1'b0;
    endtask

    task automatic drain();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            done = (exp_resp.size() == 0) && (exp_cyc.size() == 0) && (exp_grant.size() == 0);
            if (!done) tick();
        end
        if (!done) fail_now("drain_timeout");
        repeat (2) tick();
    endtask

    // Grant, ACTIVATE and response monitors
    logic rej_s;
    logic [1:0] size_s;
    logic a0_s;
    resp_t rsp;
    initial begin
        forever begin
            @(negedge CLK);
            if (mon_en) begin
                if (H_READY || A_READY) begin
                    chk("ready_onehot", {31'd0, H_READY & A_READY}, 32'd0);
                    if (exp_grant.size() == 0) fail_now("grant_unexpected");
                    else chk("grant_id", {31'd0, A_READY}, {31'd0, exp_grant.pop_front()});
                end
                chk("activate", {31'd0, FSM_ACTIVATE}, {31'd0, exp_act});
                size_s  = A_READY ? A_SIZE : H_SIZE;
                a0_s    = A_READY ? A_ADDR[0] : H_ADDR[0];
                rej_s   = (size_s == 2'd3) || (size_s != 2'd0 && a0_s);
                exp_act = (H_READY || A_READY) && !rej_s;
                if (RESP_VALID && RESP_READY) begin
                    if (exp_resp.size() == 0) fail_now("resp_unexpected");
                    else begin
                        rsp = exp_resp.pop_front();
                        chk("resp_id", {31'd0, RESP_ID}, {31'd0, rsp.id});
                        chk("resp_data", RESP_DATA, rsp.data);
                        chk("resp_err", {31'd0, RESP_ERR}, {31'd0, rsp.err});
                    end
                end
            end
        end
    end

    // Bus FSM model: two-cycle setup, LATCH, FINALIZE; chains while the expected cycle says continue.
    cyc_t cm;
    logic more;
    initial begin
        forever begin
            @(negedge CLK);
            if (model_en && FSM_ACTIVATE) begin
                more = 1'b1;
                while (more) begin
                    tick();
                    @(negedge CLK);
                    if (exp_cyc.size() == 0) begin
                        fail_now("cycle_unexpected");
                        cm   = '0;
                        more = 1'b0;
                    end else begin
                        cm = exp_cyc.pop_front();
                        chk("cyc_addr", {8'd0, CYC_ADDR}, {8'd0, cm.addr});
                        chk("cyc_wdata", {16'd0, CYC_WDATA}, {16'd0, cm.wdata});
                        chk("cyc_byte", {31'd0, CYC_BYTE}, {31'd0, cm.byt});
                        chk("cyc_rw", {31'd0, CYC_RW}, {31'd0, cm.rw});
                        chk("cyc_fc", {29'd0, CYC_FC}, {29'd0, cm.fc});
                        chk("must_continue", {31'd0, MUST_CONTINUE}, {31'd0, cm.mc});
                        more = cm.mc;
                    end
                    tick();
                    RD_WORD   = cm.rd;
                    FSM_LATCH = 1'b1;
                    tick();
                    FSM_LATCH    = 1'b0;
                    FSM_FINALIZE = 1'b1;
                    tick();
                    FSM_FINALIZE = 1'b0;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic seen;
    initial begin
        RESET = 1'b1; RESP_READY = 1'b1;
        H_VALID = 1'b0; H_ADDR = '0; H_WDATA = '0; H_SIZE = '0; H_RW = 1'b0; H_FC = '0;
        A_VALID = 1'b0; A_ADDR = '0; A_WDATA = '0; A_SIZE = '0; A_RW = 1'b0; A_FC = '0;
        FSM_FINALIZE = 1'b0; FSM_LATCH = 1'b0; RD_WORD = '0;
        repeat (3) tick();
        @(negedge CLK);
        chk("rst_activate", {31'd0, FSM_ACTIVATE}, 32'd0);
        chk("rst_must_cont", {31'd0, MUST_CONTINUE}, 32'd0);
        chk("rst_resp_valid", {31'd0, RESP_VALID}, 32'd0);
        chk("rst_cyc_addr", {8'd0, CYC_ADDR}, 32'd0);
        chk("rst_resp_data", RESP_DATA, 32'd0);
        tick();
        RESET  = 1'b0;
        mon_en = 1'b1;

        // Word read 0x000100 -> 0x0000BEEF
        exp_grant.push_back(1'b0);
        exp_cyc.push_back(mk_cyc(24'h000100, 16'h0000, 1'b0, 1'b1, 1'b0, 3'd5, 16'hBEEF));
        exp_resp.push_back(mk_resp(1'b0, 32'h0000BEEF, 1'b0));
        issue(1'b0, mk_req(24'h000100, 32'h0, 2'd1, 1'b1, 3'd5));
        drain();

        // Long write wrapping the address space
        exp_grant.push_back(1'b0);
        exp_cyc.push_back(mk_cyc(24'hFFFFFE, 16'h1234, 1'b0, 1'b0, 1'b1, 3'd1, 16'h0));
        exp_cyc.push_back(mk_cyc(24'h000000, 16'h5678, 1'b0, 1'b0, 1'b0, 3'd1, 16'h0));
        exp_resp.push_back(mk_resp(1'b0, 32'h0, 1'b0));
        issue(1'b0, mk_req(24'hFFFFFE, 32'h12345678, 2'd2, 1'b0, 3'd1));
        drain();

        // Long read assembles high word first
        exp_grant.push_back(1'b0);
        exp_cyc.push_back(mk_cyc(24'h000400, 16'h0000, 1'b0, 1'b1, 1'b1, 3'd2, 16'h1111));
        exp_cyc.push_back(mk_cyc(24'h000402, 16'h0000, 1'b0, 1'b1, 1'b0, 3'd2, 16'h2222));
        exp_resp.push_back(mk_resp(1'b0, 32'h11112222, 1'b0));
        issue(1'b0, mk_req(24'h000400, 32'h0, 2'd2, 1'b1, 3'd2));
        drain();

        // AUX byte write replicates the byte on both lanes
        exp_grant.push_back(1'b1);
        exp_cyc.push_back(mk_cyc(24'h000301, 16'hC3C3, 1'b1, 1'b0, 1'b0, 3'd6, 16'h0));
        exp_resp.push_back(mk_resp(1'b1, 32'h0, 1'b0));
        issue(1'b1, mk_req(24'h000301, 32'h000000C3, 2'd0, 1'b0, 3'd6));
        drain();

        // Rejects: odd word, reserved size, odd long
        exp_grant.push_back(1'b0);
        exp_resp.push_back(mk_resp(1'b0, 32'h0, 1'b1));
        issue(1'b0, mk_req(24'h000101, 32'h0, 2'd1, 1'b1, 3'd5));
        seen = 1'b0;
        for (int k = 0; k < 2 && !seen; k++) begin
            @(negedge CLK);
            seen = RESP_VALID;
        end
        chk("reject_latency", {31'd0, seen}, 32'd1);
        drain();
        exp_grant.push_back(1'b1);
        exp_resp.push_back(mk_resp(1'b1, 32'h0, 1'b1));
        issue(1'b1, mk_req(24'h000200, 32'h0, 2'd3, 1'b1, 3'd5));
        drain();
        exp_grant.push_back(1'b0);
        exp_resp.push_back(mk_resp(1'b0, 32'h0, 1'b1));
        issue(1'b0, mk_req(24'h000203, 32'hFFFFFFFF, 2'd2, 1'b0, 3'd5));
        drain();

        // Byte read at odd address with response back-pressure and a second request waiting
        RESP_READY = 1'b0;
        exp_grant.push_back(1'b0);
        exp_cyc.push_back(mk_cyc(24'h000201, 16'h0000, 1'b1, 1'b1, 1'b0, 3'd5, 16'hAA55));
        exp_resp.push_back(mk_resp(1'b0, 32'h00000055, 1'b0));
        exp_grant.push_back(1'b0);
        exp_cyc.push_back(mk_cyc(24'h000500, 16'hABCD, 1'b0, 1'b0, 1'b0, 3'd5, 16'h0));
        exp_resp.push_back(mk_resp(1'b0, 32'h0, 1'b0));
        fork
            begin
                issue(1'b0, mk_req(24'h000201, 32'h0, 2'd0, 1'b1, 3'd5));
                issue(1'b0, mk_req(24'h000500, 32'h0000ABCD, 2'd1, 1'b0, 3'd5));
            end
            begin
                seen = 1'b0;
                for (int k = 0; k < 200 && !seen; k++) begin
                    @(negedge CLK);
                    seen = RESP_VALID;
                end
                chk("bp_resp_seen", {31'd0, seen}, 32'd1);
                for (int k = 0; k < 5; k++) begin
                    if (k > 0) @(negedge CLK);
                    chk("bp_valid_held", {31'd0, RESP_VALID}, 32'd1);
                    chk("bp_data_stable", RESP_DATA, 32'h00000055);
                    chk("bp_no_grant", {31'd0, H_READY}, 32'd0);
                end
                tick();
                RESP_READY = 1'b1;
            end
        join
        drain();

        // Both held valid with quota 2: H H A H H A
        exp_grant.push_back(1'b0);
        exp_cyc.push_back(mk_cyc(24'h001000, 16'h1111, 1'b0, 1'b0, 1'b0, 3'd1, 16'h0));
        exp_resp.push_back(mk_resp(1'b0, 32'h0, 1'b0));
        exp_grant.push_back(1'b0);
        exp_cyc.push_back(mk_cyc(24'h001002, 16'h2222, 1'b0, 1'b0, 1'b0, 3'd1, 16'h0));
        exp_resp.push_back(mk_resp(1'b0, 32'h0, 1'b0));
        exp_grant.push_back(1'b1);
        exp_cyc.push_back(mk_cyc(24'h002000, 16'hA0A0, 1'b0, 1'b0, 1'b0, 3'd3, 16'h0));
        exp_resp.push_back(mk_resp(1'b1, 32'h0, 1'b0));
        exp_grant.push_back(1'b0);
        exp_cyc.push_back(mk_cyc(24'h001004, 16'h3333, 1'b0, 1'b0, 1'b0, 3'd1, 16'h0));
        exp_resp.push_back(mk_resp(1'b0, 32'h0, 1'b0));
        exp_grant.push_back(1'b0);
        exp_cyc.push_back(mk_cyc(24'h001006, 16'h4444, 1'b0, 1'b0, 1'b0, 3'd1, 16'h0));
        exp_resp.push_back(mk_resp(1'b0, 32'h0, 1'b0));
        exp_grant.push_back(1'b1);
        exp_cyc.push_back(mk_cyc(24'h002002, 16'hB0B0, 1'b0, 1'b0, 1'b0, 3'd3, 16'h0));
        exp_resp.push_back(mk_resp(1'b1, 32'h0, 1'b0));
        fork
            begin
                issue(1'b0, mk_req(24'h001000, 32'h00001111, 2'd1, 1'b0, 3'd1));
                issue(1'b0, mk_req(24'h001002, 32'h00002222, 2'd1, 1'b0, 3'd1));
                issue(1'b0, mk_req(24'h001004, 32'h00003333, 2'd1, 1'b0, 3'd1));
                issue(1'b0, mk_req(24'h001006, 32'h00004444, 2'd1, 1'b0, 3'd1));
            end
            begin
                issue(1'b1, mk_req(24'h002000, 32'h0000A0A0, 2'd1, 1'b0, 3'd3));
                issue(1'b1, mk_req(24'h002002, 32'h0000B0B0, 2'd1, 1'b0, 3'd3));
            end
        join
        drain();

        // RESET during phase 1 of a long drops it; the waiting HOST request runs afterwards
        model_en = 1'b0;
        exp_grant.push_back(1'b0);
        exp_grant.push_back(1'b0);
        exp_cyc.push_back(mk_cyc(24'h000700, 16'h7777, 1'b0, 1'b0, 1'b0, 3'd5, 16'h0));
        exp_resp.push_back(mk_resp(1'b0, 32'h0, 1'b0));
        fork
            begin
                issue(1'b0, mk_req(24'h000600, 32'hCAFEF00D, 2'd2, 1'b0, 3'd5));
                issue(1'b0, mk_req(24'h000700, 32'h00007777, 2'd1, 1'b0, 3'd5));
            end
            begin
                seen = 1'b0;
                for (int k = 0; k < 200 && !seen; k++) begin
                    @(negedge CLK);
                    seen = FSM_ACTIVATE;
                end
                chk("rst_run_activate_seen", {31'd0, seen}, 32'd1);
                tick();
                @(negedge CLK);
                chk("rst_run_ph0_mc", {31'd0, MUST_CONTINUE}, 32'd1);
                chk("rst_run_ph0_wdata", {16'd0, CYC_WDATA}, 32'h0000CAFE);
                tick();
                FSM_FINALIZE = 1'b1;
                tick();
                FSM_FINALIZE = 1'b0;
                @(negedge CLK);
                chk("rst_run_ph1_addr", {8'd0, CYC_ADDR}, 32'h00000602);
                chk("rst_run_ph1_wdata", {16'd0, CYC_WDATA}, 32'h0000F00D);
                chk("rst_run_ph1_mc", {31'd0, MUST_CONTINUE}, 32'd0);
                tick();
                RESET = 1'b1;
                tick();
                @(negedge CLK);
                chk("post_rst_activate", {31'd0, FSM_ACTIVATE}, 32'd0);
                chk("post_rst_must_cont", {31'd0, MUST_CONTINUE}, 32'd0);
                chk("post_rst_cyc_addr", {8'd0, CYC_ADDR}, 32'd0);
                chk("post_rst_cyc_wdata", {16'd0, CYC_WDATA}, 32'd0);
                chk("post_rst_cyc_flags", {29'd0, CYC_BYTE, CYC_RW, 1'b0}, 32'd0);
                chk("post_rst_cyc_fc", {29'd0, CYC_FC}, 32'd0);
                chk("post_rst_resp", {29'd0, RESP_VALID, RESP_ID, RESP_ERR}, 32'd0);
                chk("post_rst_resp_data", RESP_DATA, 32'd0);
                chk("post_rst_ready", {30'd0, H_READY, A_READY}, 32'd0);
                tick();
                RESET    = 1'b0;
                model_en = 1'b1;
            end
        join
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
